// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// in clk cycles, publishing each completed cycle with a one-cycle valid.
module pwm_capture #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         pwm_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         valid,
   output logic         overflow
);

   typedef enum logic {
      S_IDLE,
      S_MEAS
   } state_t;

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   state_t       r_state;
   state_t       w_state_nxt;
   logic         r_s1;
   logic         r_s2;
   logic         r_s3;
   logic         w_rise;
   logic [W-1:0] r_per_cnt;
   logic [W-1:0] r_hi_cnt;
   logic [W-1:0] w_per_nxt;
   logic [W-1:0] w_hi_nxt;
   logic         w_cap;
   logic         w_ovf_set;

   // s3 is one cycle behind s2 so a rising edge lasts exactly one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= pwm_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_per_nxt   = '0;
      w_hi_nxt    = '0;
      w_cap       = 1'b0;
      w_ovf_set   = 1'b0;
      if (!enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  w_state_nxt = S_MEAS;
                  w_per_nxt   = CNT_ONE;
                  w_hi_nxt    = CNT_ONE;
               end
            end
            S_MEAS: begin
               // the edge cycle is already the first cycle of the next period
               if (w_rise) begin
                  w_cap     = 1'b1;
                  w_per_nxt = CNT_ONE;
                  w_hi_nxt  = CNT_ONE;
               end else if (r_per_cnt == CNT_MAX) begin
                  w_ovf_set   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_per_nxt = r_per_cnt + CNT_ONE;
                  w_hi_nxt  = r_s2 ? (r_hi_cnt + CNT_ONE) : r_hi_cnt;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_per_cnt <= '0;
         r_hi_cnt  <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         r_per_cnt <= w_per_nxt;
         r_hi_cnt  <= w_hi_nxt;
         valid     <= w_cap;
         if (w_cap) begin
            period    <= r_per_cnt;
            high_time <= r_hi_cnt;
            overflow  <= 1'b0;
         end else if (w_ovf_set) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table vectors, random waveforms against a
// period-list model, and hand sequences for overflow, enable and reset.
module tb_pwm_capture;

   logic        clk;
   logic        rst_n;
   logic        en16;
   logic        pwm16;
   logic [15:0] period16;
   logic [15:0] high16;
   logic        valid16;
   logic        ovf16;
   logic        en4;
   logic        pwm4;
   logic [3:0]  period4;
   logic [3:0]  high4;
   logic        valid4;
   logic        ovf4;

   int tests;
   int fails;
   int cyc;
   int last_v;

   pwm_capture #(.W(16)) dut16 (
      .clk      (clk),
      .reset_n  (rst_n),
      .enable   (en16),
      .pwm_in   (pwm16),
      .period   (period16),
      .high_time(high16),
      .valid    (valid16),
      .overflow (ovf16)
   );

   pwm_capture #(.W(4)) dut4 (
      .clk      (clk),
      .reset_n  (rst_n),
      .enable   (en4),
      .pwm_in   (pwm4),
      .period   (period4),
      .high_time(high4),
      .valid    (valid4),
      .overflow (ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   typedef struct {
      int per;
      int hi;
      bit gap;
   } exp_t;

   exp_t q[$];
   bit   have_prev;
   int   prev_per;
   int   prev_hi;
   int   run_cnt;

   typedef struct {
      int h;
      int l;
      int reps;
      int ep;
      int eh;
   } vec_t;

   vec_t tbl[7];

   int v4_cnt;
   int v4_per;
   int v4_hi;
   int v4_ovf;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid16) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: got per=%0d hi=%0d expected none",
                     period16, high16);
         end else begin
            e = q.pop_front();
            if (period16 !== 16'(e.per) || high16 !== 16'(e.hi) || ovf16 !== 1'b0) begin
               fails++;
               $display("FAIL meas: got per=%0d hi=%0d ovf=%0d expected per=%0d hi=%0d ovf=0",
                        period16, high16, ovf16, e.per, e.hi);
            end
            if (e.gap) chk("valid_spacing", cyc - last_v, e.per);
         end
         last_v = cyc;
      end
   end

   always @(negedge clk) begin
      if (valid4) begin
         v4_cnt++;
         v4_per = int'(period4);
         v4_hi  = int'(high4);
         v4_ovf = int'(ovf4);
      end
   end

   // One PWM cycle on dut16; the rise that starts it completes the previous one
   task automatic drive_period(int h, int l, int ep, int eh);
      if (have_prev) begin
         q.push_back('{prev_per, prev_hi, run_cnt > 0});
         run_cnt++;
      end
      pwm16 = 1'b1;
      repeat (h) @(negedge clk);
      pwm16 = 1'b0;
      repeat (l) @(negedge clk);
      have_prev = en16;
      prev_per  = ep;
      prev_hi   = eh;
   endtask

   task automatic drive4(int h, int l);
      pwm4 = 1'b1;
      repeat (h) @(negedge clk);
      pwm4 = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   initial begin
      int  h;
      int  l;
      int  ovf_at;
      int  nv;
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      last_v    = 0;
      have_prev = 1'b0;
      run_cnt   = 0;
      v4_cnt    = 0;
      v4_per    = 0;
      v4_hi     = 0;
      v4_ovf    = 0;
      prev_per  = 0;
      prev_hi   = 0;

      tbl[0] = '{3, 5, 4, 8, 3};
      tbl[1] = '{1, 1, 3, 2, 1};
      tbl[2] = '{7, 2, 3, 9, 7};
      tbl[3] = '{64, 192, 2, 256, 64};
      tbl[4] = '{192, 64, 2, 256, 192};
      tbl[5] = '{1, 2, 3, 3, 1};
      tbl[6] = '{4, 4, 2, 8, 4};

      rst_n = 1'b0;
      en16  = 1'b1;
      en4   = 1'b1;
      pwm16 = 1'b0;
      pwm4  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_period", int'(period16), 0);
      chk("rst_high", int'(high16), 0);
      chk("rst_valid", int'(valid16), 0);
      chk("rst_ovf", int'(ovf16), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // W=4: single edge, then saturation after 15 counted cycles
      pwm4   = 1'b1;
      ovf_at = 0;
      nv     = v4_cnt;
      for (int i = 1; i <= 40 && ovf_at == 0; i++) begin
         @(negedge clk);
         pwm4 = 1'b0;
         if (ovf4) ovf_at = i;
      end
      chk("ovf_latency", ovf_at, 18);
      chk("ovf_no_valid", v4_cnt - nv, 0);
      chk("ovf_period_hold", int'(period4), 0);
      drive4(2, 2);
      chk("ovf_after_arm", int'(ovf4), 1);
      chk("arm_no_valid", v4_cnt, 0);
      drive4(2, 2);
      chk("w4_cnt1", v4_cnt, 1);
      chk("w4_per4", v4_per, 4);
      chk("w4_hi2", v4_hi, 2);
      chk("w4_ovf_clr", v4_ovf, 0);
      chk("w4_ovf_now", int'(ovf4), 0);
      drive4(7, 8);
      chk("w4_cnt2", v4_cnt, 2);
      drive4(1, 3);
      chk("w4_cnt3", v4_cnt, 3);
      chk("w4_per_max", v4_per, 15);
      chk("w4_hi7", v4_hi, 7);
      chk("w4_max_no_ovf", int'(ovf4), 0);

      foreach (tbl[k]) begin
         for (int r = 0; r < tbl[k].reps; r++) begin
            drive_period(tbl[k].h, tbl[k].l, tbl[k].ep, tbl[k].eh);
         end
      end

      for (int n = 0; n < 40; n++) begin
         h = int'($urandom_range(1, 20));
         l = int'($urandom_range(1, 20));
         drive_period(h, l, h + l, h);
      end

      // enable dropped during the low phase of a 4/4 cycle
      drive_period(4, 4, 8, 4);
      drive_period(4, 4, 8, 4);
      q.push_back('{prev_per, prev_hi, run_cnt > 0});
      pwm16 = 1'b1;
      repeat (4) @(negedge clk);
      pwm16 = 1'b0;
      repeat (2) @(negedge clk);
      en16 = 1'b0;
      repeat (2) @(negedge clk);
      have_prev = 1'b0;
      run_cnt   = 0;
      for (int n = 0; n < 3; n++) drive_period(4, 4, 8, 4);
      chk("dis_period_hold", int'(period16), 8);
      chk("dis_high_hold", int'(high16), 4);
      chk("dis_q_empty", q.size(), 0);
      en16 = 1'b1;
      repeat (2) @(negedge clk);
      for (int n = 0; n < 3; n++) drive_period(4, 4, 8, 4);
      drive_period(2, 2, 4, 2);

      // asynchronous reset between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_period", int'(period16), 0);
      chk("async_high", int'(high16), 0);
      chk("async_valid", int'(valid16), 0);
      chk("async_ovf", int'(ovf16), 0);
      chk("async_period4", int'(period4), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      have_prev = 1'b0;
      run_cnt   = 0;
      q.delete();
      for (int n = 0; n < 3; n++) drive_period(5, 3, 8, 5);
      drive_period(1, 1, 2, 1);
      repeat (4) @(negedge clk);
      chk("final_q_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
